// File: rtl/mem_arbiter.sv
// Two-requester (loader / core) arbiter in front of a shared single-port RAM.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed loader priority.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; winner's fields latched on the way out
// ACCESS | RAM driven from latched fields, winner's grant pulsed
// RESP   | read data returned on rdata with rvalid, tagged with rid
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              ld_gnt,
    output logic              cpu_gnt,
    output logic              rvalid,
    output logic              rid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic                r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_any_req;
    logic                w_pick_cpu;
    logic                w_latch;

    assign w_any_req = ld_req | cpu_req;
    assign w_latch   = (r_state == S_IDLE) && w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last = 1 means the core won most recently; reset to core so the loader wins the first tie
    logic r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_latch) begin
            r_last <= w_pick_cpu;
        end
    end

    assign w_pick_cpu = cpu_req & (~ld_req | ~r_last);
`else
    assign w_pick_cpu = cpu_req & ~ld_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = r_we ? S_IDLE : S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_id    <= w_pick_cpu;
            r_we    <= w_pick_cpu ? cpu_we    : ld_we;
            r_addr  <= w_pick_cpu ? cpu_addr  : ld_addr;
            r_wdata <= w_pick_cpu ? cpu_wdata : ld_wdata;
        end
    end

    // RAM address/data follow the latch registers so they hold between accesses
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    always_comb begin
        ld_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        ram_we  = 1'b0;
        rvalid  = 1'b0;
        rid     = 1'b0;
        rdata   = '0;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_ACCESS: begin
                ld_gnt  = ~r_id;
                cpu_gnt = r_id;
                ram_we  = r_we;
            end
            S_RESP: begin
                rvalid = 1'b1;
                rid    = r_id;
                rdata  = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/read responses,
// a negedge monitor pops and compares whenever the DUT presents gnt or rvalid.
module tb_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ld_gnt, cpu_gnt, rvalid, rid, ram_we, busy;
    logic [DW-1:0] rdata, ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ld_gnt(ld_gnt), .cpu_gnt(cpu_gnt),
        .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } gnt_exp_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } rd_exp_t;

    gnt_exp_t gq[$];
    rd_exp_t  rq[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_gnt(input logic id, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        gnt_exp_t e;
        e.id = id; e.we = we; e.addr = addr; e.data = data;
        gq.push_back(e);
    endtask

    task automatic exp_rd(input logic id, input logic [DW-1:0] data);
        rd_exp_t e;
        e.id = id; e.data = data;
        rq.push_back(e);
    endtask

    // Hold request and fields until this requester's grant, then release
    task automatic req_access(input logic id, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
        logic got;
        got = 1'b0;
        if (id) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        end else begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = data;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = id ? cpu_gnt : ld_gnt;
        end
        if (id) cpu_req = 1'b0;
        else    ld_req  = 1'b0;
        chk(id ? "cpu_gnt_wait" : "ld_gnt_wait", 32'(got), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ld_gnt || cpu_gnt || rvalid)
                chk("out_exclusive", 32'(int'(ld_gnt) + int'(cpu_gnt) + int'(rvalid)), 32'd1);
            if (!(ld_gnt || cpu_gnt))
                chk("ram_we_outside_access", 32'(ram_we), 32'd0);
            if (ld_gnt || cpu_gnt) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_gnt: actual ld=%0b cpu=%0b required=none", ld_gnt, cpu_gnt);
                end else begin
                    gnt_exp_t e;
                    e = gq.pop_front();
                    chk("gnt_id", 32'(cpu_gnt), 32'(e.id));
                    chk("gnt_we", 32'(ram_we), 32'(e.we));
                    chk("gnt_addr", 32'(ram_addr), 32'(e.addr));
                    if (e.we) chk("gnt_wdata", 32'(ram_wdata), 32'(e.data));
                end
            end
            if (rvalid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: actual rid=%0b rdata=%0h required=none", rid, rdata);
                end else begin
                    rd_exp_t r;
                    r = rq.pop_front();
                    chk("rid", 32'(rid), 32'(r.id));
                    chk("rdata", 32'(rdata), 32'(r.data));
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'({ld_gnt, cpu_gnt}), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rdata_rid", 32'({rid, rdata}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // loader write then core read of the same word
        exp_gnt(1'b0, 1'b1, 5'd5, 16'hBEEF);
        req_access(1'b0, 1'b1, 5'd5, 16'hBEEF);
        exp_gnt(1'b1, 1'b0, 5'd5, 16'h0);
        exp_rd(1'b1, 16'hBEEF);
        req_access(1'b1, 1'b0, 5'd5, 16'h0);

        // single-read latency: gnt N+1, rvalid N+2, idle N+3
        repeat (3) @(negedge clk);
        exp_gnt(1'b0, 1'b0, 5'd5, 16'h0);
        exp_rd(1'b0, 16'hBEEF);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 5'd5;
        @(negedge clk);
        chk("lat_gnt_n1", 32'(ld_gnt), 32'd1);
        chk("lat_busy_n1", 32'(busy), 32'd1);
        chk("lat_rvalid_n1", 32'(rvalid), 32'd0);
        ld_req = 1'b0;
        @(negedge clk);
        chk("lat_rvalid_n2", 32'(rvalid), 32'd1);
        chk("lat_busy_n2", 32'(busy), 32'd1);
        chk("lat_gnt_n2", 32'({ld_gnt, cpu_gnt}), 32'd0);
        @(negedge clk);
        chk("lat_busy_n3", 32'(busy), 32'd0);

        // core drops req right after latching: exactly one access
        exp_gnt(1'b1, 1'b1, 5'd9, 16'h0909);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd9; cpu_wdata = 16'h0909;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(cpu_gnt);
        end
        chk("drop_single_gnt", 32'(n), 32'd1);
        exp_gnt(1'b0, 1'b0, 5'd9, 16'h0);
        exp_rd(1'b0, 16'h0909);
        req_access(1'b0, 1'b0, 5'd9, 16'h0);

        // reset during ACCESS of a write aborts it
        repeat (3) @(negedge clk);
        exp_gnt(1'b0, 1'b1, 5'd7, 16'h5555);
        req_access(1'b0, 1'b1, 5'd7, 16'h5555);
        repeat (2) @(negedge clk);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 5'd7; ld_wdata = 16'hDEAD;
        @(posedge clk);
        #1 chk("abort_pre_ram_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_gnt", 32'({ld_gnt, cpu_gnt}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        ld_req = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_gnt(1'b1, 1'b0, 5'd7, 16'h0);
        exp_rd(1'b1, 16'h5555);
        req_access(1'b1, 1'b0, 5'd7, 16'h0);
        exp_gnt(1'b0, 1'b1, 5'd7, 16'h1234);
        req_access(1'b0, 1'b1, 5'd7, 16'h1234);
        exp_gnt(1'b1, 1'b0, 5'd7, 16'h0);
        exp_rd(1'b1, 16'h1234);
        req_access(1'b1, 1'b0, 5'd7, 16'h0);

        // contention from a fresh reset: loader 4 writes, core 2 writes
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_gnt(1'b0, 1'b1, 5'd10, 16'h1000);
        exp_gnt(1'b1, 1'b1, 5'd20, 16'h2000);
        exp_gnt(1'b0, 1'b1, 5'd11, 16'h1001);
        exp_gnt(1'b1, 1'b1, 5'd21, 16'h2001);
        exp_gnt(1'b0, 1'b1, 5'd12, 16'h1002);
        exp_gnt(1'b0, 1'b1, 5'd13, 16'h1003);
`else
        exp_gnt(1'b0, 1'b1, 5'd10, 16'h1000);
        exp_gnt(1'b0, 1'b1, 5'd11, 16'h1001);
        exp_gnt(1'b0, 1'b1, 5'd12, 16'h1002);
        exp_gnt(1'b0, 1'b1, 5'd13, 16'h1003);
        exp_gnt(1'b1, 1'b1, 5'd20, 16'h2000);
        exp_gnt(1'b1, 1'b1, 5'd21, 16'h2001);
`endif
        fork
            begin
                for (int i = 0; i < 4; i++)
                    req_access(1'b0, 1'b1, AW'(10 + i), DW'(16'h1000 + i));
            end
            begin
                for (int j = 0; j < 2; j++)
                    req_access(1'b1, 1'b1, AW'(20 + j), DW'(16'h2000 + j));
            end
        join
        exp_gnt(1'b0, 1'b0, 5'd21, 16'h0);
        exp_rd(1'b0, 16'h2001);
        req_access(1'b0, 1'b0, 5'd21, 16'h0);

        for (int k = 0; k < 20 && (gq.size() != 0 || rq.size() != 0); k++)
            @(negedge clk);
        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rd_queue_drained", 32'(rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameters (name, default, meaning): ADDR_W, 5, RAM word-address width; DATA_W, 16, RAM data width.
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: ld_req, ld_we  input  1 each  loader (requester 0) request and write-not-read.
- REQ-005: ld_addr  input  ADDR_W, ld_wdata  input  DATA_W  loader address and write data.
- REQ-006: cpu_req, cpu_we  input  1 each  core (requester 1) request and write-not-read.
- REQ-007: cpu_addr  input  ADDR_W, cpu_wdata  input  DATA_W  core address and write data.
- REQ-008: ld_gnt, cpu_gnt  output  1 each  one-cycle grant pulse per accepted access.
- REQ-009: rvalid  output  1, rid  output  1, rdata  output  DATA_W  read response; rid is 0 for loader, 1 for core.
- REQ-010: ram_addr  output  ADDR_W, ram_wdata  output  DATA_W, ram_we  output  1  shared single-port RAM drive.
- REQ-011: ram_rdata  input  DATA_W  RAM read data, valid one cycle after the address is presented.
- REQ-012: busy  output  1  high in any state other than IDLE.

Function
- REQ-013: FSM states SHALL be IDLE, ACCESS and RESP.
- REQ-014: IDLE: when any request is high, arbitrate, latch the winner's we/addr/wdata and identity, and go to ACCESS; otherwise stay in IDLE.
- REQ-015: ACCESS lasts one cycle: drive ram_addr/ram_wdata/ram_we from the latched fields, pulse the winner's gnt, then go to RESP for a read or IDLE for a write.
- REQ-016: RESP lasts one cycle: rvalid=1, rdata=ram_rdata, rid=latched identity, then go to IDLE.
- REQ-017: Latency: request seen in IDLE at cycle N gives gnt at N+1; read data (rvalid) at N+2; a write is performed at N+1.
- REQ-018: Throughput: at most one access per 2 cycles for writes and per 3 cycles for reads.
- REQ-019: ram_we SHALL be 1 only in ACCESS for a latched write; outside ACCESS, ram_we=0 and ram_addr/ram_wdata hold their last latched values.
- REQ-020: At most one of ld_gnt/cpu_gnt SHALL be high in any cycle; gnt and rvalid SHALL never be high in the same cycle.
- REQ-021: A requester SHALL hold req and its fields stable until its gnt; deassertion after latching is ignored, and the latched access completes.
- REQ-022: A requester still asserting req in the gnt cycle is treated as a new request at the next IDLE.
- REQ-023: The last-winner register is updated on every latch.

Reset
- REQ-024: While rst_n=0, immediately and independent of clk: state=IDLE, all gnt/rvalid/ram_we/busy=0, ram_addr/ram_wdata/rdata/rid=0, last-winner=core (so the loader wins the first tie).
- REQ-025: Reset in ACCESS or RESP aborts the access: no gnt, rvalid or ram_we after reset asserts; operation resumes from IDLE on the first edge after release.

Configuration
- REQ-026: Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester that did not win last is granted.
- REQ-027: ARB_ROUND_ROBIN_EN undefined: fixed priority, loader always beats core; last-winner register absent.

Verification
- REQ-028: Loader write addr 5 data 16'hBEEF, then core read addr 5 -> ram_we pulse at N+1, later rvalid=1, rid=1, rdata=16'hBEEF.
- REQ-029: ld_req and cpu_req high together for 4 accesses -> round robin gives gnt order loader, core, loader, core; fixed priority gives loader 4 times with core starved.
- REQ-030: Single read at cycle N -> gnt at N+1, rvalid at N+2, busy high N+1..N+2, back in IDLE at N+3.
- REQ-031: rst_n low during ACCESS of a write -> ram_we falls immediately, no gnt; next request after release is served normally.
- REQ-032: Core drops cpu_req the cycle after latching -> access still completes with one cpu_gnt; no second access is issued.
- REQ-033: Random traffic for 10k cycles -> never two gnts at once, never gnt together with rvalid, every rvalid matches a scoreboard model.
